// File: rtl/spi_main_if.sv
// Command/response handshake between a requester and the SPI main controller.
// master = requester side, slave = controller side.
interface spi_main_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         done;
  logic         cmd_error;
  logic         busy;

  modport master (
    output cmd_valid, cmd, wdata,
    input  cmd_ready, rdata, done, cmd_error, busy
  );

  modport slave (
    input  cmd_valid, cmd, wdata,
    output cmd_ready, rdata, done, cmd_error, busy
  );
endinterface

// File: rtl/spi_main.sv
// SPI main controller: frames one subnode command per handshake (csb, 5-bit cmd, payload).
// Optional SPI_MAIN_MISO_SYNC_EN adds a two-flop miso synchroniser and delays capture by 2 cycles.
module spi_main #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CSB_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_main_if.slave  bus,
  output logic       sck,
  output logic       csb,
  output logic       mosi,
  input  logic       miso
);

  // IDLE wait cmd | LOW/HIGH one sck period per bit | TAIL final low | GAP csb high, done on last cycle
  typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, GAP} state_t;

`ifdef SPI_MAIN_MISO_SYNC_EN
  localparam int unsigned TAIL_LEN = (CLK_DIV > 3) ? CLK_DIV : 3;
`else
  localparam int unsigned TAIL_LEN = CLK_DIV;
`endif

  state_t         state_q;
  logic [7:0]     cnt_q;
  logic [7:0]     bits_q;
  logic [7:0]     n_q;
  logic [131:0]   sh_q;
  logic [127:0]   cap_q;
  logic [127:0]   rdata_q;
  logic           rd_q;
  logic           sck_q, csb_q, mosi_q, busy_q, done_q, err_q, ready_q;

  logic           dec_ok, dec_rd;
  logic [7:0]     dec_n;
  logic [131:0]   dec_sh;
  logic           cap_fall, cap_en, cap_bit;

  always_comb begin
    dec_ok = 1'b1;
    dec_rd = bus.cmd[4];
    dec_n  = 8'd128;
    case (bus.cmd)
      5'd0, 5'd1, 5'd2, 5'd16, 5'd17, 5'd18:  dec_n = 8'd128;
      5'd3, 5'd19:                            dec_n = 8'd3;
      5'd20, 5'd21, 5'd22, 5'd23, 5'd24:      dec_n = 8'd64;
      default:                                dec_ok = 1'b0;
    endcase
    // Remaining bits after cmd[4], left-aligned so the shifter always emits from bit 131
    dec_sh = {bus.cmd[3:0], 128'b0};
    if (!dec_rd) begin
      if (dec_n == 8'd3) dec_sh = {bus.cmd[3:0], bus.wdata[2:0], 125'b0};
      else               dec_sh = {bus.cmd[3:0], bus.wdata};
    end
  end

  assign cap_fall = (state_q == HIGH) && (cnt_q == 8'd0) && (bits_q <= n_q);

`ifdef SPI_MAIN_MISO_SYNC_EN
  logic miso_s1_q, miso_s2_q, cap_p1_q, cap_p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      cap_p1_q  <= 1'b0;
      cap_p2_q  <= 1'b0;
    end else begin
      miso_s1_q <= miso;
      miso_s2_q <= miso_s1_q;
      cap_p1_q  <= cap_fall;
      cap_p2_q  <= cap_p1_q;
    end
  end

  assign cap_en  = cap_p2_q;
  assign cap_bit = miso_s2_q;
`else
  assign cap_en  = cap_fall;
  assign cap_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cap_en) cap_q <= {cap_q[126:0], cap_bit};
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            if (dec_ok) begin
              state_q <= LOW;
              cnt_q   <= 8'(CLK_DIV - 1);
              bits_q  <= dec_n + 8'd5;
              n_q     <= dec_n;
              sh_q    <= dec_sh;
              cap_q   <= '0;
              rd_q    <= dec_rd;
              csb_q   <= 1'b0;
              mosi_q  <= bus.cmd[4];
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOW: begin
          if (cnt_q == 8'd0) begin
            state_q <= HIGH;
            sck_q   <= 1'b1;
            cnt_q   <= 8'(CLK_DIV - 1);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        HIGH: begin
          if (cnt_q == 8'd0) begin
            sck_q <= 1'b0;
            if (bits_q == 8'd1) begin
              state_q <= TAIL;
              cnt_q   <= 8'(TAIL_LEN - 1);
            end else begin
              state_q <= LOW;
              cnt_q   <= 8'(CLK_DIV - 1);
              bits_q  <= bits_q - 8'd1;
              mosi_q  <= sh_q[131];
              sh_q    <= {sh_q[130:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        TAIL: begin
          if (cnt_q == 8'd0) begin
            state_q <= GAP;
            csb_q   <= 1'b1;
            cnt_q   <= 8'(CSB_GAP);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        GAP: begin
          // CSB_GAP cycles of csb high, then one extra cycle carrying done
          if (cnt_q == 8'd1) begin
            done_q <= 1'b1;
            if (rd_q) rdata_q <= cap_q;
          end
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sck           = sck_q;
  assign csb           = csb_q;
  assign mosi          = mosi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.cmd_error = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/spi_main.md
# spi_main

SPI main controller that drives the Ascon core's SPI subnode from the host side of the design, either on a test harness or as an on-chip bridge. It accepts one command at a time over a valid/ready handshake and serialises it as a complete framed transaction: csb low, 5-bit command MSB first, then the write payload or read capture. It generates `sck` from the system clock and returns read data right-aligned.

## Interface
- `CLK_DIV`, default 2: sck half-period in `clk` cycles; legal range 1..255.
- `CSB_GAP`, default 2: minimum `clk` cycles csb stays high between transactions; must be at least 1.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; transfer accepted when `cmd_valid & cmd_ready`.
- `cmd`  in  5  subnode command code.
- `wdata`  in  128  write payload, right-aligned; sampled at acceptance.
- `rdata`  out  128  read result, right-aligned, upper bits zero.
- `done`  out  1  one-cycle pulse at transaction end.
- `cmd_error`  out  1  one-cycle pulse on an unsupported command.
- `busy`  out  1  high from acceptance until the return to IDLE.
- `sck`  out  1  SPI clock; idle low.
- `csb`  out  1  chip select, active low; idle high.
- `mosi`  out  1  serial data to the subnode.
- `miso`  in  1  serial data from the subnode.

## Operation
- Payload length N and direction decoded from `cmd` at acceptance:
  - 00000–00010: write, N=128.
  - 00011: write, N=3.
  - 10000–10010: read, N=128.
  - 10011: read, N=3.
  - 10100–11000: read, N=64.
  - Any other code: no transaction; `cmd_error` pulses the cycle after acceptance; block stays in IDLE.
- Transaction length is B=5+N bits.
- Bit stream on `mosi`:
  - `cmd[4:0]` MSB first.
  - Writes: then `wdata[N-1:0]` MSB first.
  - Reads: then N zeros.
- FSM states: IDLE → LOW → HIGH, with LOW/HIGH repeated B times → TAIL → GAP → IDLE.
  - LOW: sck=0 for CLK_DIV cycles.
  - HIGH: sck=1 for CLK_DIV cycles.
  - TAIL: sck=0 for CLK_DIV cycles, csb still low.
  - GAP: csb=1 for CSB_GAP cycles.
- `mosi` changes only on entry to LOW; it is stable throughout each rising sck edge, which is when the subnode samples it.
- Read capture:
  - Bits are sampled on each sck falling transition (entry to LOW or TAIL) that follows rising edge k, for k=6..5+N.
  - Each sample shifts into the LSB of the capture register, so the fall after edge 6 yields bit N-1 and the fall after edge 5+N yields bit 0.
  - `rdata` is loaded in the `done` cycle. It holds its value otherwise, and writes do not change it.
- `cmd_valid` while busy is ignored; the requester holds the request.
- Reset values: `sck`=0, `csb`=1, `mosi`=0, `busy`=0, `done`=0, `cmd_error`=0, `rdata`=0, state IDLE.
- Asserting `rst_n` mid-transaction returns all outputs to reset values immediately. Because csb rises, the subnode is also reset; no `done` is issued.

## Timing
- With acceptance in cycle T:
  - `csb` falls at T+1 and `mosi`=cmd[4] at T+1.
  - `csb` rises at T+1+CLK_DIV·(2B+1).
  - `done` pulses at T+1+CLK_DIV·(2B+1)+CSB_GAP.
  - `cmd_ready` returns high in the cycle after `done`.
- Example with defaults: WR_REG0 gives `done` at T+537; RD_OP_MODE gives `done` at T+37.
- Back-to-back commands: csb is high for at least CSB_GAP+1 cycles.

## Configuration
- `SPI_MAIN_MISO_SYNC_EN` defined:
  - Two-flop synchroniser on `miso`.
  - Each capture point is delayed 2 `clk` cycles after the sck fall.
  - Requires CLK_DIV≥3; capture for the final bit extends TAIL to max(CLK_DIV, 3) cycles.
- Not defined: `miso` sampled directly at the fall cycle; TAIL is exactly CLK_DIV.

## Test plan
- WR_REG0 with `wdata`=128'h0123456789ABCDEF_FEDCBA9876543210, subnode model attached → model reg0 equals the value; `done` at T+537; `csb` high afterwards.
- Then RD_REG0 → `rdata`=128'h0123456789ABCDEF_FEDCBA9876543210; `mosi` low for all payload bits.
- WR_OP_MODE with `wdata`=3'b101, then RD_OP_MODE → `rdata`=128'h5; model `operation_ready`=1 after the write.
- RD_S_2 with model S_2=64'hDEADBEEF01234567 → `rdata`=128'h0000…DEADBEEF01234567.
- `cmd`=5'b01000 → `cmd_error` pulse at T+1; `csb` never low; `busy` stays 0.
- `rst_n` low at bit 40 of WR_REG1 → `csb`=1, `sck`=0 in the same cycle; a subsequent WR_REG1 succeeds.
- `cmd_valid` held continuously → each `csb` high interval is ≥ CSB_GAP+1 cycles.
